// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, ALU control word, operand-B select
// and the per-opcode commit helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_OR  = 4'h3,
        OP_AND = 4'h4, OP_INC = 4'h5, OP_DEC = 4'h6, OP_NOT = 4'h7,
        OP_NEG = 4'h8, OP_SHL = 4'h9, OP_ROR = 4'hA, OP_ROL = 4'hB,
        OP_LDI = 4'hC, OP_CMP = 4'hD, OP_NOP = 4'hE, OP_ILL = 4'hF
    } op_e;

    typedef struct packed {
        logic ci;
        logic nb;
        logic ic;
        logic na;
        logic xo;
        logic no;
        logic sr;
        logic ss;
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        B_REG  = 3'd0,
        B_ZERO = 3'd1,
        B_ONE  = 3'd2,
        B_A    = 3'd3,
        B_ROL  = 3'd4
    } b_sel_e;

    function automatic logic writes_rd(input op_e op);
        logic w;
        case (op)
            OP_CMP, OP_NOP, OP_ILL: w = 1'b0;
            default:                w = 1'b1;
        endcase
        return w;
    endfunction

    function automatic logic writes_flags(input op_e op);
        logic w;
        case (op)
            OP_LDI, OP_NOP, OP_ILL: w = 1'b0;
            default:                w = 1'b1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu16.sv
// 16-bit ALU: optional operand inversion, add-with-carry or carry-inhibited XOR/OR,
// output inversion, and a right rotate (or arithmetic shift) by B[3:0].
module alu16
    import alu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  alu_ctrl_t   ctrl,
    output logic [15:0] y,
    output logic        cf,
    output logic        zf
);

    logic [15:0] a_s;
    logic [15:0] b_s;
    logic [15:0] r_s;
    logic [16:0] sum_s;
    logic [4:0]  lsh_s;
    logic        c_s;

    // Datapath: operand conditioning, function select, output inversion and flags.
    always_comb begin
        a_s   = ctrl.na ? ~a : a;
        b_s   = ctrl.nb ? ~b : b;
        sum_s = {1'b0, a_s} + {1'b0, b_s} + {16'h0000, ctrl.ci};
        lsh_s = 5'd16 - {1'b0, b[3:0]};
        c_s   = 1'b0;
        if (ctrl.sr) begin
            if (ctrl.ss) begin
                r_s = $unsigned($signed(a) >>> b[3:0]);
            end else begin
                r_s = (a >> b[3:0]) | (a << lsh_s);
            end
        end else if (ctrl.ic) begin
            r_s = ctrl.xo ? (a_s | b_s) : (a_s ^ b_s);
        end else begin
            r_s = sum_s[15:0];
            c_s = sum_s[16];
        end
        y  = ctrl.no ? ~r_s : r_s;
        cf = c_s;
        zf = (y == 16'h0000);
    end

endmodule

// File: rtl/alu_decode.sv
// Opcode decoder: maps a micro-op to the ALU control word, the operand-B source
// and an illegal-opcode indication.
module alu_decode
    import alu_pkg::*;
(
    input  op_e       op,
    output alu_ctrl_t ctrl,
    output b_sel_e    b_sel,
    output logic      illegal
);

    // Opcode to control-bit table; unlisted bits stay 0 and ss is never set.
    always_comb begin
        ctrl    = '0;
        b_sel   = B_REG;
        illegal = 1'b0;
        case (op)
            OP_ADD:         b_sel = B_REG;
            OP_SUB, OP_CMP: begin ctrl.ci = 1'b1; ctrl.nb = 1'b1; end
            OP_XOR:         ctrl.ic = 1'b1;
            OP_OR:          begin ctrl.ic = 1'b1; ctrl.xo = 1'b1; end
            OP_AND: begin
                ctrl.ic = 1'b1; ctrl.na = 1'b1; ctrl.nb = 1'b1;
                ctrl.no = 1'b1; ctrl.xo = 1'b1;
            end
            OP_INC:         begin ctrl.ci = 1'b1; b_sel = B_ZERO; end
            OP_DEC:         begin ctrl.nb = 1'b1; b_sel = B_ZERO; end
            OP_NOT:         begin ctrl.nb = 1'b1; ctrl.ic = 1'b1; b_sel = B_ZERO; end
            OP_NEG:         begin ctrl.ci = 1'b1; ctrl.na = 1'b1; b_sel = B_ZERO; end
            OP_SHL:         b_sel = B_A;
            OP_ROR:         begin ctrl.sr = 1'b1; b_sel = B_ONE; end
            OP_ROL:         begin ctrl.sr = 1'b1; b_sel = B_ROL; end
            OP_LDI, OP_NOP: b_sel = B_REG;
            default:        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage: reads operands (with forwarding from the pending result),
// runs the ALU, holds one result in the WB register and commits it on handshake.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic [7:0]        in_imm,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [RA_W-1:0]   res_rd,
    output logic              flag_c,
    output logic              flag_z,
    output logic              err,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [RA_W-1:0]   res_rd_q, res_rd_d;
    logic              wr_q, wr_d;
    logic              wf_q, wf_d;
    logic              cf_q, cf_d;
    logic              zf_q, zf_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;
    logic              err_q, err_d;

    op_e               op_s;
    alu_ctrl_t         ctrl_s;
    b_sel_e            b_sel_s;
    logic              illegal_s;
    logic              fwd_ok_s;
    logic              accept_s;
    logic              fire_s;
    logic [DATA_W-1:0] a_s, b_reg_s, b_s, alu_y_s, ex_data_s;
    logic              alu_cf_s, alu_zf_s;

    assign op_s      = op_e'(in_op);
    assign in_ready  = !res_valid_q || res_ready;
    assign accept_s  = in_valid && in_ready;
    assign fire_s    = res_valid_q && res_ready;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign err       = err_q;
    assign dbg_data  = rf_q[dbg_addr];

    alu_decode u_decode (
        .op      (op_s),
        .ctrl    (ctrl_s),
        .b_sel   (b_sel_s),
        .illegal (illegal_s)
    );

    alu16 u_alu (
        .a    (a_s),
        .b    (b_s),
        .ctrl (ctrl_s),
        .y    (alu_y_s),
        .cf   (alu_cf_s),
        .zf   (alu_zf_s)
    );

    // EX operands: the pending WB result overrides the register file when it will write rd.
    always_comb begin
        fwd_ok_s = res_valid_q && wr_q && (res_rd_q != '0);
        if (in_rs1 == '0) begin
            a_s = '0;
        end else if (fwd_ok_s && (res_rd_q == in_rs1)) begin
            a_s = res_data_q;
        end else begin
            a_s = rf_q[in_rs1];
        end
        if (in_rs2 == '0) begin
            b_reg_s = '0;
        end else if (fwd_ok_s && (res_rd_q == in_rs2)) begin
            b_reg_s = res_data_q;
        end else begin
            b_reg_s = rf_q[in_rs2];
        end
        case (b_sel_s)
            B_REG:   b_s = b_reg_s;
            B_ZERO:  b_s = '0;
            B_ONE:   b_s = DATA_W'(1'b1);
            B_A:     b_s = a_s;
            B_ROL:   b_s = DATA_W'(4'hF);
            default: b_s = '0;
        endcase
        if (illegal_s || (op_s == OP_NOP)) begin
            ex_data_s = '0;
        end else if (op_s == OP_LDI) begin
            ex_data_s = DATA_W'(in_imm);
        end else begin
            ex_data_s = alu_y_s;
        end
    end

    // Next state: commit the WB register on fire, then reload it on accept (same edge allowed).
    always_comb begin
        rf_d        = rf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        wr_d        = wr_q;
        wf_d        = wf_q;
        cf_d        = cf_q;
        zf_d        = zf_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        err_d       = err_q;
        if (fire_s) begin
            res_valid_d = 1'b0;
            if (wr_q && (res_rd_q != '0)) begin
                rf_d[res_rd_q] = res_data_q;
            end else begin
                rf_d[0] = '0;
            end
            if (wf_q) begin
                flag_c_d = cf_q;
                flag_z_d = zf_q;
            end else begin
                flag_c_d = flag_c_q;
                flag_z_d = flag_z_q;
            end
        end else begin
            res_valid_d = res_valid_q;
        end
        if (accept_s) begin
            res_valid_d = 1'b1;
            res_data_d  = ex_data_s;
            res_rd_d    = in_rd;
            wr_d        = writes_rd(op_s);
            wf_d        = writes_flags(op_s);
            cf_d        = alu_cf_s;
            zf_d        = alu_zf_s;
            err_d       = err_q | illegal_s;
        end else begin
            err_d = err_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            wr_q        <= 1'b0;
            wf_q        <= 1'b0;
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            wr_q        <= wr_d;
            wf_q        <= wf_d;
            cf_q        <= cf_d;
            zf_q        <= zf_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random op streams
// checked against an architectural (program-order) model of registers and flags.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic [7:0]  in_imm;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_rd;
    logic        flag_c, flag_z, err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_rf [8];
    logic        m_c, m_z, m_err;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
        .flag_c(flag_c), .flag_z(flag_z), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
    endtask

    // Architectural effect of one op, applied in program order.
    task automatic model_exec(input logic [3:0] op, input logic [2:0] rd, rs1, rs2,
                              input logic [7:0] imm, output logic [15:0] data, output logic chk);
        logic [15:0] a, b;
        logic [16:0] t;
        logic        c, wr, wf;
        a = (rs1 == 3'd0) ? 16'h0000 : m_rf[rs1];
        b = (rs2 == 3'd0) ? 16'h0000 : m_rf[rs2];
        c = 1'b0; wr = 1'b1; wf = 1'b1; chk = 1'b1;
        case (op)
            4'h0: begin t = a + b; data = t[15:0]; c = t[16]; end
            4'h1: begin data = a - b; c = (a >= b); end
            4'h2: data = a ^ b;
            4'h3: data = a | b;
            4'h4: data = a & b;
            4'h5: begin data = a + 16'd1; c = (a == 16'hFFFF); end
            4'h6: begin data = a - 16'd1; c = (a != 16'h0000); end
            4'h7: data = ~a;
            4'h8: begin data = 16'h0000 - a; c = (a == 16'h0000); end
            4'h9: begin data = a << 1; c = a[15]; end
            4'hA: data = {a[0], a[15:1]};
            4'hB: data = {a[14:0], a[15]};
            4'hC: begin data = {8'h00, imm}; wf = 1'b0; end
            4'hD: begin data = a - b; c = (a >= b); wr = 1'b0; end
            4'hE: begin data = 16'h0000; chk = 1'b0; wr = 1'b0; wf = 1'b0; end
            default: begin data = 16'h0000; wr = 1'b0; wf = 1'b0; m_err = 1'b1; end
        endcase
        if (wr && (rd != 3'd0)) m_rf[rd] = data;
        if (wf) begin m_c = c; m_z = (data == 16'h0000); end
    endtask

    // Drive one op with res_ready=1; the result beat must appear right after acceptance.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, rs1, rs2, input logic [7:0] imm);
        logic [15:0] exp;
        logic        chk;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        res_ready = 1'b1;
        model_exec(op, rd, rs1, rs2, imm, exp, chk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL issue_ready op=%h got=%b want=1", op, in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (res_valid !== 1'b1 || res_rd !== rd || (chk && res_data !== exp)) begin
            n_errors++;
            $display("FAIL result op=%h got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h",
                     op, res_valid, res_rd, res_data, rd, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || flag_c !== 1'b0 || flag_z !== 1'b0 || err !== 1'b0) begin
            n_errors++; $display("FAIL reset_outs got v=%b c=%b z=%b e=%b want 0000",
                                 res_valid, flag_c, flag_z, err);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            n_checks++;
            if (dbg_data !== 16'h0000) begin
                n_errors++; $display("FAIL reset_rf r%0d got=%h want=0000", i, dbg_data);
            end
        end
    endtask

    task automatic test_add();
        issue(4'hC, 3'd1, 3'd0, 3'd0, 8'd9);
        issue(4'hC, 3'd2, 3'd0, 3'd0, 8'd8);
        issue(4'h0, 3'd3, 3'd1, 3'd2, 8'd0);
        idle();
        dbg_addr = 3'd3; #1;
        n_checks++;
        if (dbg_data !== 16'd17 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            n_errors++; $display("FAIL add r3=%h c=%b z=%b want 0011 0 0", dbg_data, flag_c, flag_z);
        end
    endtask

    task automatic test_back_to_back();
        issue(4'hC, 3'd1, 3'd0, 3'd0, 8'd10);
        issue(4'h1, 3'd1, 3'd1, 3'd1, 8'd0);
        idle();
        dbg_addr = 3'd1; #1;
        n_checks++;
        if (dbg_data !== 16'h0000 || flag_z !== 1'b1) begin
            n_errors++; $display("FAIL back_to_back r1=%h z=%b want 0000 1", dbg_data, flag_z);
        end
    endtask

    task automatic test_unary();
        logic [15:0] want [4];
        want[0] = 16'hFFF0; want[1] = 16'h0008; want[2] = 16'h0020; want[3] = 16'hFFEF;
        issue(4'hC, 3'd1, 3'd0, 3'd0, 8'd16);
        issue(4'h8, 3'd4, 3'd1, 3'd0, 8'd0);
        issue(4'hA, 3'd5, 3'd1, 3'd0, 8'd0);
        issue(4'hB, 3'd6, 3'd1, 3'd0, 8'd0);
        issue(4'h7, 3'd7, 3'd1, 3'd0, 8'd0);
        idle();
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 3'(i + 4); #1;
            n_checks++;
            if (dbg_data !== want[i]) begin
                n_errors++; $display("FAIL unary r%0d got=%h want=%h", i + 4, dbg_data, want[i]);
            end
        end
    endtask

    task automatic test_carry();
        issue(4'hC, 3'd1, 3'd0, 3'd0, 8'd1);
        issue(4'h7, 3'd1, 3'd1, 3'd0, 8'd0);
        issue(4'hC, 3'd2, 3'd0, 3'd0, 8'd2);
        issue(4'hC, 3'd3, 3'd0, 3'd0, 8'h55);
        issue(4'hD, 3'd0, 3'd1, 3'd2, 8'd0);
        idle();
        dbg_addr = 3'd3; #1;
        n_checks++;
        if (dbg_data !== 16'h0055) begin
            n_errors++; $display("FAIL cmp_nowrite r3=%h want=0055", dbg_data);
        end
        issue(4'h0, 3'd3, 3'd1, 3'd2, 8'd0);
        idle();
        dbg_addr = 3'd3; #1;
        n_checks++;
        if (dbg_data !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            n_errors++; $display("FAIL add_carry r3=%h c=%b z=%b want 0000 1 1", dbg_data, flag_c, flag_z);
        end
    endtask

    task automatic test_stall();
        logic [15:0] e1, e2;
        logic        k;
        @(negedge clk);
        res_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'hC; in_rd = 3'd2; in_rs1 = 3'd0; in_rs2 = 3'd0; in_imm = 8'h33;
        model_exec(4'hC, 3'd2, 3'd0, 3'd0, 8'h33, e1, k);
        @(posedge clk); #1;
        @(negedge clk);
        in_op = 4'h0; in_rd = 3'd3; in_rs1 = 3'd2; in_rs2 = 3'd2; in_imm = 8'h00;
        model_exec(4'h0, 3'd3, 3'd2, 3'd2, 8'h00, e2, k);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_errors++; $display("FAIL stall_ready cyc=%0d got=%b want=0", i, in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== e1 || res_rd !== 3'd2) begin
                n_errors++; $display("FAIL stall_hold cyc=%0d got v=%b d=%h rd=%0d want 1 %h 2",
                                     i, res_valid, res_data, res_rd, e1);
            end
        end
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== e2 || res_rd !== 3'd3) begin
            n_errors++; $display("FAIL stall_second got v=%b d=%h rd=%0d want 1 %h 3",
                                 res_valid, res_data, res_rd, e2);
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_drain got v=%b want 0", res_valid);
        end
        dbg_addr = 3'd3; #1;
        n_checks++;
        if (dbg_data !== 16'h0066) begin
            n_errors++; $display("FAIL stall_commit r3=%h want=0066", dbg_data);
        end
    endtask

    task automatic test_illegal();
        issue(4'hF, 3'd2, 3'd1, 3'd1, 8'd0);
        idle();
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++; $display("FAIL illegal_err got=%b want=1", err);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            n_checks++;
            if (dbg_data !== m_rf[i]) begin
                n_errors++; $display("FAIL illegal_rf r%0d got=%h want=%h", i, dbg_data, m_rf[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        idle();
        n_checks++;
        if (flag_c !== m_c || flag_z !== m_z || err !== m_err) begin
            n_errors++; $display("FAIL random_flags got c=%b z=%b e=%b want c=%b z=%b e=%b",
                                 flag_c, flag_z, err, m_c, m_z, m_err);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            n_checks++;
            if (dbg_data !== m_rf[i]) begin
                n_errors++; $display("FAIL random_rf r%0d got=%h want=%h", i, dbg_data, m_rf[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        issue(4'hC, 3'd5, 3'd0, 3'd0, 8'h77);
        issue(4'h9, 3'd6, 3'd5, 3'd0, 8'd0);
        @(negedge clk);
        rst = 1'b1; #1;
        n_checks++;
        if (res_valid !== 1'b0 || res_data !== 16'h0000 || res_rd !== 3'd0 ||
            flag_c !== 1'b0 || flag_z !== 1'b0 || err !== 1'b0) begin
            n_errors++; $display("FAIL midreset_outs v=%b d=%h rd=%0d c=%b z=%b e=%b want all 0",
                                 res_valid, res_data, res_rd, flag_c, flag_z, err);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            n_checks++;
            if (dbg_data !== 16'h0000) begin
                n_errors++; $display("FAIL midreset_rf r%0d got=%h want=0000", i, dbg_data);
            end
        end
        in_valid = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b0;
        issue(4'hC, 3'd1, 3'd0, 3'd0, 8'd5);
        idle();
        dbg_addr = 3'd1; #1;
        n_checks++;
        if (dbg_data !== 16'h0005 || err !== 1'b0) begin
            n_errors++; $display("FAIL post_reset r1=%h e=%b want 0005 0", dbg_data, err);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_imm = 8'h00; res_ready = 1'b1; dbg_addr = 3'd0;
        model_reset();
        test_reset();
        @(negedge clk); rst = 1'b0;
        test_add();
        test_back_to_back();
        test_unary();
        test_carry();
        test_stall();
        test_illegal();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
